registrador_desloc_param: RTL

//  Parametrised shift register with parallel load, the successor of the fixed 7-bit display register.

---
 rtl/registrador_pkg.sv | 26 ++
 rtl/flipflop_registrador_param.sv | 60 ++++++
 rtl/registrador_desloc_param.sv | 138 +++++++++++++
 3 files changed

// File: rtl/registrador_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : registrador_pkg
//  Description : Shared encodings for the parametrised scrolling shift
//                register: shift modes and sequencer states.
//  Revision    : 1.0 - initial release
// ============================================================================
package registrador_pkg;

  // Shift mode encodings, as seen on the modo port
  typedef enum logic [1:0] {
    MODO_ESQ    = 2'b00,  // shift towards MSB, d_serial enters at bit 0
    MODO_DIR    = 2'b01,  // shift towards LSB, d_serial enters at MSB
    MODO_ROT    = 2'b10,  // rotate towards MSB, MSB wraps to bit 0
    MODO_PARADO = 2'b11   // hold contents (step still counted)
  } modo_t;

  // Automatic scroll sequencer states
  typedef enum logic [1:0] {
    OCIOSO     = 2'b00,
    DESLOCANDO = 2'b01,
    FIM        = 2'b10
  } estado_t;

endpackage : registrador_pkg
`default_nettype wire

// File: rtl/flipflop_registrador_param.sv
`default_nettype none
// ============================================================================
//  Module      : flipflop_registrador_param
//  Description : One bit cell of the shift register. Holds a single bit and
//                selects between hold, parallel load and a shift from the
//                lower or upper neighbour according to the mode.
//  Ports       : clk, reset     - clock / synchronous active-high reset
//                d_carga        - parallel load bit
//                viz_menor      - neighbour at index i-1 (or end-cell input)
//                viz_maior      - neighbour at index i+1 (or end-cell input)
//                modo           - shift mode
//                en_carga       - parallel load enable (wins over shift)
//                en_desloc      - shift step enable
//                q              - stored bit
//  Revision    : 1.0 - initial release
// ============================================================================
module flipflop_registrador_param
  import registrador_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  d_carga,
  input  logic  viz_menor,
  input  logic  viz_maior,
  input  modo_t modo,
  input  logic  en_carga,
  input  logic  en_desloc,
  output logic  q
);

  logic bit_q;
  logic bit_d;

  always_comb begin
    bit_d = bit_q;
    if (en_carga) begin
      bit_d = d_carga;
    end else if (en_desloc) begin
      unique case (modo)
        MODO_ESQ,
        MODO_ROT:    bit_d = viz_menor;
        MODO_DIR:    bit_d = viz_maior;
        MODO_PARADO: bit_d = bit_q;
        default:     bit_d = bit_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bit_q <= 1'b0;
    end else begin
      bit_q <= bit_d;
    end
  end

  assign q = bit_q;

endmodule : flipflop_registrador_param
`default_nettype wire

// File: rtl/registrador_desloc_param.sv
`default_nettype none
// ============================================================================
//  Module      : registrador_desloc_param
//  Description : Parametrised shift register with parallel load, selectable
//                direction / rotation / hold and an automatic scroll
//                sequencer that performs NUM_DESLOC tick-paced steps after
//                iniciar and then pulses fim for one cycle.
//  Ports       : clk, reset     - clock / synchronous active-high reset
//                bits           - parallel load value
//                carregar       - parallel load strobe (aborts a sequence)
//                modo           - 00 ESQ, 01 DIR, 10 ROT, 11 PARADO
//                d_serial       - serial input bit
//                iniciar        - start automatic sequence
//                tick           - shift-enable pulse
//                saidas         - register contents
//                saida_serial   - outgoing end bit for the active direction
//                ocupado        - sequence in progress
//                fim            - one-cycle completion pulse
//  Revision    : 1.0 - initial release
// ============================================================================
module registrador_desloc_param
  import registrador_pkg::*;
#(
  parameter int LARGURA    = 7,
  parameter int NUM_DESLOC = 7
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [LARGURA-1:0] bits,
  input  logic               carregar,
  input  logic [1:0]         modo,
  input  logic               d_serial,
  input  logic               iniciar,
  input  logic               tick,
  output logic [LARGURA-1:0] saidas,
  output logic               saida_serial,
  output logic               ocupado,
  output logic               fim
);

  localparam int                CONT_W   = $clog2(NUM_DESLOC + 1);
  localparam logic [CONT_W-1:0] C_ULTIMO = CONT_W'(NUM_DESLOC - 1);

  modo_t              modo_s;
  estado_t            estado_q;
  estado_t            estado_d;
  logic [CONT_W-1:0]  cont_q;
  logic [CONT_W-1:0]  cont_d;
  logic               en_desloc;
  logic [LARGURA-1:0] reg_q;
  logic [LARGURA-1:0] viz_menor;
  logic [LARGURA-1:0] viz_maior;
  logic               entrada_lsb;

  assign modo_s = modo_t'(modo);

  // ---------------------------------------------------------------------------
  // Sequencer: next state and step counter
  // ---------------------------------------------------------------------------
  always_comb begin
    estado_d  = estado_q;
    cont_d    = cont_q;
    en_desloc = 1'b0;
    if (carregar) begin
      // A load always aborts a running sequence without a fim pulse
      estado_d = OCIOSO;
      cont_d   = '0;
    end else begin
      unique case (estado_q)
        OCIOSO: begin
          if (iniciar) begin
            estado_d = DESLOCANDO;
            cont_d   = '0;
          end
        end
        DESLOCANDO: begin
          if (tick) begin
            en_desloc = 1'b1;
            cont_d    = cont_q + CONT_W'(1);
            if (cont_q == C_ULTIMO) begin
              estado_d = FIM;
            end
          end
        end
        FIM: begin
          estado_d = OCIOSO;
        end
        default: begin
          estado_d = OCIOSO;
          cont_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      estado_q <= OCIOSO;
      cont_q   <= '0;
    end else begin
      estado_q <= estado_d;
      cont_q   <= cont_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Neighbour routing. Only the end cells see something other than an adjacent
  // bit: bit 0 takes d_serial (ESQ) or the wrapped MSB (ROT), and the MSB takes
  // d_serial when shifting right.
  // ---------------------------------------------------------------------------
  assign entrada_lsb = (modo_s == MODO_ROT) ? reg_q[LARGURA-1] : d_serial;
  assign viz_menor   = {reg_q[LARGURA-2:0], entrada_lsb};
  assign viz_maior   = {d_serial, reg_q[LARGURA-1:1]};

  for (genvar i = 0; i < LARGURA; i++) begin : g_celulas
    flipflop_registrador_param u_celula (
      .clk       (clk),
      .reset     (reset),
      .d_carga   (bits[i]),
      .viz_menor (viz_menor[i]),
      .viz_maior (viz_maior[i]),
      .modo      (modo_s),
      .en_carga  (carregar),
      .en_desloc (en_desloc),
      .q         (reg_q[i])
    );
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign saidas       = reg_q;
  assign saida_serial = (modo_s == MODO_DIR) ? reg_q[0] : reg_q[LARGURA-1];
  assign ocupado      = (estado_q == DESLOCANDO);
  assign fim          = (estado_q == FIM);

endmodule : registrador_desloc_param
`default_nettype wire
